conv33_output_writer: RTL and testbench
=======================================

Name: conv33_output_writer

Overview:
- Sits directly downstream of the conv33 output control stage. It consumes output_valid-qualified signed accumulator results from the 3x3 convolution.
- Applies optional ReLU, rounds with a right shift, and saturates each result to OUT_W bits. It packs PACK pixels per word and writes them to the output feature-map memory with row-aware addressing.
- Pulses frame_done after the last word of a frame has been written.

Parameters:
- ACC_W, 20, signed accumulator width of in_data.
- OUT_W, 8, signed output pixel width.
- SHIFT, 8, requantization right-shift amount. Must be at least 1.
- IMG_W, 26, output pixels per row.
- IMG_H, 26, output rows per frame.
- PACK, 4, pixels per memory word.
- ADDR_W, 10, write address width. Must satisfy 2^ADDR_W >= IMG_H*ceil(IMG_W/PACK).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that arms a new frame.
- relu_en  in  1  enables ReLU. Sampled at start and held for the whole frame.
- in_valid  in  1  in_data valid this cycle. Driven from conv33 output_valid.
- in_data  in  ACC_W  signed accumulator result.
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  PACK*OUT_W  packed pixels. Lane 0 is in bits [OUT_W-1:0].
- busy  out  1  high from the cycle after start until frame_done.
- frame_done  out  1  one-cycle pulse at frame end.
- sat_flag  out  1  sticky. Set when any pixel saturates. Cleared by start.
- drop_err  out  1  sticky. Set when in_valid arrives while idle. Cleared by start.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst_n is asynchronous and active-low.
  - On reset all outputs are 0, the FSM is IDLE, and all counters and the pack register are cleared.
  - Reset mid-frame abandons the frame with no further writes and no frame_done.
- FSM states are IDLE, RUN and DONE.
  - IDLE -> RUN on start. This latches relu_en and clears the counters, sat_flag and drop_err.
  - RUN -> DONE in the cycle the final word's wr_en is issued.
  - DONE -> IDLE after one cycle, with frame_done=1 during that cycle.
  - start in RUN or DONE is ignored.
  - in_valid in IDLE or DONE is dropped and sets drop_err.
- Stage 1, requantize (registered, 1 cycle):
  - s = in_data + 2^(SHIFT-1), computed at ACC_W+1 bits.
  - q = s >>> SHIFT (arithmetic shift).
  - If relu_en and in_data < 0, then q = 0.
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set sat_flag if clipped.
- Stage 2, pack:
  - A lane counter (0..PACK-1) and a column counter (0..IMG_W-1) advance on each valid stage-1 result.
  - The pixel is written into the lane given by the lane counter.
  - A word completes when lane = PACK-1 or column = IMG_W-1.
  - A row-end partial word has its unused upper lanes forced to 0.
  - On word completion: wr_en=1 for one cycle, wr_addr = word counter, then the word counter increments, the lane resets to 0 and the pack register clears.
  - At column IMG_W-1 the column wraps to 0 and the row increments.
  - The final word is the one completed at row IMG_H-1, column IMG_W-1.
- Latency:
  - in_valid at cycle t gives the stage-1 result at t+1.
  - If that pixel completes a word, wr_en is asserted at t+2.
  - frame_done is asserted at t+3 relative to the last pixel.
- Throughput is one pixel per cycle, back-to-back, with no backpressure.
- Gaps in in_valid simply stall the counters.
- The total number of words is IMG_H*ceil(IMG_W/PACK), which is 182 with the defaults (addresses 0..181).
- Pixels arriving after the final word in the same frame are dropped and set drop_err.

Decomposition:
- Shared package conv33_pkg holds:
  - ACC_W, OUT_W, IMG_W, IMG_H, PACK as constants;
  - the WORDS_PER_ROW = ceil(IMG_W/PACK) function;
  - the FSM state enum.
- One sub-module, conv33_requant: the combinational round/shift/ReLU/saturate logic, registered in the parent.

Test Plan:
- Reset and idle:
  - Apply rst_n=0 mid-RUN, then release -> all outputs 0, FSM IDLE, no frame_done.
  - Then in_valid=1 without start -> drop_err=1, no wr_en.
- Rounding:
  - start with relu_en=0, in_data=896 -> pixel 4.
  - in_data=-300 -> pixel 0xFF (-1).
  - in_data=40000 -> pixel 127 and sat_flag=1.
- ReLU:
  - relu_en=1, in_data=-300 -> pixel 0x00.
  - in_data=-40000 -> pixel 0x00 and sat_flag stays 0.
- Packing and row end:
  - Feed pixels equal to 1..26 for row 0 (in_data = k*256).
  - Expect 7 writes at addresses 0..6; word 0 = 0x04030201.
  - Word 6 = 0x00001A19.
  - Each wr_en appears 2 cycles after the completing in_valid.
- Full frame:
  - 676 back-to-back in_valid cycles -> 182 writes at addresses 0..181.
  - frame_done pulses exactly once, one cycle after the addr-181 write; busy then falls.
- Gapped input and ignored start:
  - Random 50% in_valid gaps -> identical wr_data/wr_addr sequence to the back-to-back case.
  - start during RUN -> no counter reset.

Source files
------------

// File: rtl/conv33_pkg.sv
// Shared constants, state encoding and sizing helper for the conv33 output path.
package conv33_pkg;

    localparam int ACC_W = 20;
    localparam int OUT_W = 8;
    localparam int IMG_W = 26;
    localparam int IMG_H = 26;
    localparam int PACK  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int words_per_row(input int img_w, input int pack);
        return (img_w + pack - 1) / pack;
    endfunction

endpackage

// File: rtl/conv33_requant.sv
// Round-half-up right shift, optional ReLU and signed saturation of one accumulator value.
module conv33_requant #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] data_i,
    input  logic                    relu_en_i,
    output logic        [OUT_W-1:0] pix_o,
    output logic                    sat_o
);

    localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;

    // One extra bit keeps the rounding add from wrapping at the positive limit.
    always_comb begin
        sum     = $signed({data_i[ACC_W-1], data_i}) + RND;
        shifted = sum >>> SHIFT;
        pix_o   = shifted[OUT_W-1:0];
        sat_o   = 1'b0;
        if (relu_en_i && data_i[ACC_W-1]) begin
            pix_o = '0;
        end else if (shifted > MAX_V) begin
            pix_o = MAX_V[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (shifted < MIN_V) begin
            pix_o = MIN_V[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/conv33_output_writer.sv
// Requantizes conv33 results, packs PACK pixels per word and writes a frame with row-aware addressing.
//   state   | meaning
//   IDLE    | waiting for start; incoming pixels are dropped
//   RUN     | accepting pixels and writing packed words
//   DONE    | final word issued; frame_done follows next cycle
module conv33_output_writer #(
    parameter int ACC_W  = conv33_pkg::ACC_W,
    parameter int OUT_W  = conv33_pkg::OUT_W,
    parameter int SHIFT  = 8,
    parameter int IMG_W  = conv33_pkg::IMG_W,
    parameter int IMG_H  = conv33_pkg::IMG_H,
    parameter int PACK   = conv33_pkg::PACK,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    relu_en,
    input  logic                    in_valid,
    input  logic signed [ACC_W-1:0] in_data,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [PACK*OUT_W-1:0]   wr_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    sat_flag,
    output logic                    drop_err
);

    import conv33_pkg::*;

    localparam int WORDS  = IMG_H * words_per_row(IMG_W, PACK);
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    state_e                 state_q, state_d;
    logic                   relu_q;
    logic                   s1_valid_q;
    logic [OUT_W-1:0]       s1_pix_q;
    logic                   s1_sat_q;
    logic [LANE_W-1:0]      lane_q;
    logic [COL_W-1:0]       col_q;
    logic [ADDR_W-1:0]      word_q;
    logic [PACK*OUT_W-1:0]  pack_q;
    logic                   wr_en_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [PACK*OUT_W-1:0]  wr_data_q;
    logic                   frame_done_q;
    logic                   sat_q;
    logic                   drop_q;

    logic [OUT_W-1:0]       req_pix;
    logic                   req_sat;
    logic                   in_run;
    logic                   accept;
    logic                   row_end;
    logic                   word_end;
    logic                   last_word;
    logic [PACK*OUT_W-1:0]  word_nx;

    conv33_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .data_i    (in_data),
        .relu_en_i (relu_q),
        .pix_o     (req_pix),
        .sat_o     (req_sat)
    );

    always_comb begin
        in_run    = (state_q == ST_RUN);
        accept    = s1_valid_q && in_run;
        row_end   = (col_q == COL_W'(IMG_W - 1));
        word_end  = accept && ((lane_q == LANE_W'(PACK - 1)) || row_end);
        last_word = word_end && (word_q == ADDR_W'(WORDS - 1));
        // Unused upper lanes of a row-end word stay zero because pack_q clears per word.
        word_nx   = pack_q;
        for (int l = 0; l < PACK; l++) begin
            if (lane_q == LANE_W'(l)) begin
                word_nx[l*OUT_W +: OUT_W] = s1_pix_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (last_word) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            relu_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_pix_q     <= '0;
            s1_sat_q     <= 1'b0;
            lane_q       <= '0;
            col_q        <= '0;
            word_q       <= '0;
            pack_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            sat_q        <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= 1'b0;
            frame_done_q <= (state_q == ST_DONE);
            s1_valid_q   <= in_valid && in_run;
            if (in_valid && in_run) begin
                s1_pix_q <= req_pix;
                s1_sat_q <= req_sat;
            end

            if (start && state_q == ST_IDLE) begin
                relu_q <= relu_en;
                lane_q <= '0;
                col_q  <= '0;
                word_q <= '0;
                pack_q <= '0;
                sat_q  <= 1'b0;
                drop_q <= 1'b0;
            end else begin
                // Late stage-1 results after the final word count as drops too.
                if ((in_valid && !in_run) || (s1_valid_q && !in_run)) begin
                    drop_q <= 1'b1;
                end
                if (accept && s1_sat_q) begin
                    sat_q <= 1'b1;
                end
            end

            if (accept) begin
                if (word_end) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= word_q;
                    wr_data_q <= word_nx;
                    word_q    <= word_q + 1'b1;
                    lane_q    <= '0;
                    pack_q    <= '0;
                end else begin
                    lane_q <= lane_q + 1'b1;
                    pack_q <= word_nx;
                end
                col_q <= row_end ? '0 : col_q + 1'b1;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE) || frame_done_q;
    assign sat_flag   = sat_q;
    assign drop_err   = drop_q;

endmodule

// File: tb/tb_conv33_output_writer.sv
// Directed bench for conv33_output_writer: reset, rounding, ReLU, row packing, full and gapped frames.
module tb_conv33_output_writer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               relu_en = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [19:0] in_data = '0;
    logic               wr_en;
    logic [9:0]         wr_addr;
    logic [31:0]        wr_data;
    logic               busy;
    logic               frame_done;
    logic               sat_flag;
    logic               drop_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int drv_cyc  = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          fd_cnt = 0;
    int          fd_cyc = 0;
    logic        fd_prev = 1'b0;
    logic        busy_after_fd = 1'b1;
    logic [31:0] exp_w [182];

    conv33_output_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .relu_en    (relu_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .sat_flag   (sat_flag),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (fd_prev) busy_after_fd = busy;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        fd_prev = frame_done;
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        fd_cnt = 0;
        fd_cyc = 0;
        busy_after_fd = 1'b1;
    endtask

    task automatic reset_dut();
        #3 rst_n = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
    endtask

    task automatic do_start(input logic relu);
        start = 1'b1;
        relu_en = relu;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pix(input logic signed [19:0] d);
        in_valid = 1'b1;
        in_data = d;
        drv_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic feed_frame(input bit gapped, input bit mid_start, input bit extra);
        reset_dut();
        do_start(1'b0);
        for (int i = 0; i < 676; i++) begin
            if (gapped) begin
                while ($urandom_range(0, 1) == 0) idle(1);
            end
            if (mid_start && i == 300) start = 1'b1;
            in_valid = 1'b1;
            in_data = 20'((i % 64) * 256);
            drv_cyc = cyc;
            @(posedge clk);
            #1 in_valid = 1'b0;
            start = 1'b0;
        end
        if (extra) pix(20'sd512);
        for (int k = 0; k < 50 && fd_cnt == 0; k++) idle(1);
        idle(3);
    endtask

    task automatic test_reset();
        reset_dut();
        do_start(1'b0);
        for (int k = 1; k <= 10; k++) pix(20'(k * 256));
        reset_dut();
        n_assert++;
        if ({wr_en, busy, frame_done, sat_flag, drop_err} !== 5'b0 || wr_addr !== 10'd0 || wr_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b busy=%b fd=%b sat=%b drop=%b addr=%0d data=%h, want all 0",
                     wr_en, busy, frame_done, sat_flag, drop_err, wr_addr, wr_data);
        end
        idle(10);
        n_assert++;
        if (wa_q.size() != 0 || fd_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_abandon: got writes=%0d frame_done=%0d, want 0 and 0", wa_q.size(), fd_cnt);
        end
        pix(20'sd256);
        idle(4);
        n_assert++;
        if (drop_err !== 1'b1 || wa_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_drop: got drop=%b writes=%0d busy=%b, want 1 0 0", drop_err, wa_q.size(), busy);
        end
    endtask

    task automatic test_rounding();
        reset_dut();
        do_start(1'b0);
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        pix(20'sd896);
        pix(-20'sd300);
        pix(20'sd40000);
        pix(20'sd0);
        idle(3);
        n_assert++;
        if (wa_q.size() != 1 || wd_q[0] !== 32'h007FFF04 || wa_q[0] !== 10'd0) begin
            n_fail++;
            $display("FAIL round_word: got n=%0d data=%h addr=%0d, want 1 007fff04 0",
                     wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'hx, (wa_q.size() > 0) ? wa_q[0] : 10'hx);
        end
        n_assert++;
        if (sat_flag !== 1'b1 || drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL round_sat: got sat=%b drop=%b want 1 0", sat_flag, drop_err);
        end
    endtask

    task automatic test_relu();
        reset_dut();
        do_start(1'b1);
        pix(-20'sd300);
        pix(-20'sd40000);
        pix(20'sd512);
        pix(20'sd0);
        idle(3);
        n_assert++;
        if (wa_q.size() != 1 || wd_q[0] !== 32'h00020000) begin
            n_fail++;
            $display("FAIL relu_word: got n=%0d data=%h want 1 00020000",
                     wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'hx);
        end
        n_assert++;
        if (sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL relu_sat: got %b want 0", sat_flag);
        end
    endtask

    task automatic test_row_pack();
        int c4;
        int c26;
        reset_dut();
        do_start(1'b0);
        c4 = 0;
        c26 = 0;
        for (int k = 1; k <= 26; k++) begin
            pix(20'(k * 256));
            if (k == 4) c4 = drv_cyc;
            if (k == 26) c26 = drv_cyc;
        end
        idle(4);
        n_assert++;
        if (wa_q.size() != 7) begin
            n_fail++;
            $display("FAIL row_count: got %0d writes want 7", wa_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_assert++;
                if (wa_q[i] !== 10'(i)) begin
                    n_fail++;
                    $display("FAIL row_addr: write %0d got %0d want %0d", i, wa_q[i], i);
                end
            end
            n_assert++;
            if (wd_q[0] !== 32'h04030201) begin
                n_fail++;
                $display("FAIL row_word0: got %h want 04030201", wd_q[0]);
            end
            n_assert++;
            if (wd_q[6] !== 32'h00001A19) begin
                n_fail++;
                $display("FAIL row_word6: got %h want 00001a19", wd_q[6]);
            end
            n_assert++;
            if (wc_q[0] != c4 + 2 || wc_q[6] != c26 + 2) begin
                n_fail++;
                $display("FAIL row_latency: got cycles %0d,%0d want %0d,%0d", wc_q[0], wc_q[6], c4 + 2, c26 + 2);
            end
        end
    endtask

    task automatic build_model();
        for (int w = 0; w < 182; w++) exp_w[w] = '0;
        for (int r = 0; r < 26; r++) begin
            for (int c = 0; c < 26; c++) begin
                exp_w[r*7 + c/4][(c%4)*8 +: 8] = 8'((r*26 + c) % 64);
            end
        end
    endtask

    task automatic test_full_frame();
        int last_drv;
        feed_frame(1'b0, 1'b0, 1'b1);
        last_drv = drv_cyc - 1;
        n_assert++;
        if (wa_q.size() != 182) begin
            n_fail++;
            $display("FAIL full_count: got %0d writes want 182", wa_q.size());
        end else begin
            for (int i = 0; i < 182; i++) begin
                n_assert++;
                if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL full_word: idx %0d got addr=%0d data=%h want addr=%0d data=%h",
                             i, wa_q[i], wd_q[i], i, exp_w[i]);
                end
            end
            n_assert++;
            if (wc_q[181] != last_drv + 2) begin
                n_fail++;
                $display("FAIL full_last_latency: got cycle %0d want %0d", wc_q[181], last_drv + 2);
            end
            n_assert++;
            if (fd_cnt != 1 || fd_cyc != wc_q[181] + 1) begin
                n_fail++;
                $display("FAIL full_frame_done: got count=%0d cycle=%0d want 1 at %0d", fd_cnt, fd_cyc, wc_q[181] + 1);
            end
        end
        n_assert++;
        if (busy_after_fd !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_busy_fall: got %b/%b want 0/0", busy_after_fd, busy);
        end
        n_assert++;
        if (drop_err !== 1'b1) begin
            n_fail++;
            $display("FAIL full_late_drop: got drop=%b want 1", drop_err);
        end
    endtask

    task automatic test_gapped_start();
        feed_frame(1'b1, 1'b1, 1'b0);
        n_assert++;
        if (wa_q.size() != 182) begin
            n_fail++;
            $display("FAIL gap_count: got %0d writes want 182", wa_q.size());
        end else begin
            for (int i = 0; i < 182; i++) begin
                n_assert++;
                if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL gap_word: idx %0d got addr=%0d data=%h want addr=%0d data=%h",
                             i, wa_q[i], wd_q[i], i, exp_w[i]);
                end
            end
        end
        n_assert++;
        if (fd_cnt != 1 || drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_done: got frame_done=%0d drop=%b want 1 0", fd_cnt, drop_err);
        end
    endtask

    initial begin
        build_model();
        idle(2);
        #1 rst_n = 1'b1;
        test_reset();
        test_rounding();
        test_relu();
        test_row_pack();
        test_full_frame();
        test_gapped_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
